// File: rtl/circuito_decodificador_funcionalidade_seq_pkg.sv
// Shared constants for the function-code decoder: FSM state encodings,
// function code values and counter width.
package circuito_decodificador_funcionalidade_seq_pkg;

    localparam int CNT_W = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_GAP    = 2'd2;

    localparam logic [2:0] CODE_NONE = 3'd0;
    localparam logic [2:0] CODE_A    = 3'd1;
    localparam logic [2:0] CODE_B    = 3'd2;
    localparam logic [2:0] CODE_C    = 3'd3;
    localparam logic [2:0] CODE_D    = 3'd4;
    localparam logic [2:0] CODE_E    = 3'd5;
    localparam logic [2:0] CODE_F    = 3'd6;
    localparam logic [2:0] CODE_G    = 3'd7;

endpackage

// File: rtl/circuito_decodificador_funcionalidade_seq_if.sv
// Code-in / strobe-out bus of the function-code decoder.
// Handshake: a code is transferred on every rising clock edge where
// CF_VALID and CF_READY are both high; the source keeps CF stable and
// CF_VALID high until that edge, and CF_VALID without CF_READY does nothing.
interface circuito_decodificador_funcionalidade_seq_if;
    logic [2:0] CF;
    logic       CF_VALID;
    logic       CF_READY;
    logic [6:0] SEL;
    logic       BUSY;
    logic       DONE;
    logic       NULL_CODE;

    modport master (
        output CF, CF_VALID,
        input  CF_READY, SEL, BUSY, DONE, NULL_CODE
    );

    modport slave (
        input  CF, CF_VALID,
        output CF_READY, SEL, BUSY, DONE, NULL_CODE
    );
endinterface

// File: rtl/circuito_decodificador_funcionalidade_seq_dec3x7.sv
// Combinational 3-bit function code to 7-bit one-hot line map.
// SEL[6] = A ... SEL[0] = G; code 000 gives all lines low.
module decodificador_3x7
    import circuito_decodificador_funcionalidade_seq_pkg::*;
(
    input  logic [2:0] i_code,
    output logic [6:0] o_sel
);

    // Map each code to its single function line
    always_comb begin
        o_sel = 7'b0000000;
        case (i_code)
            CODE_A:  o_sel = 7'b1000000;
            CODE_B:  o_sel = 7'b0100000;
            CODE_C:  o_sel = 7'b0010000;
            CODE_D:  o_sel = 7'b0001000;
            CODE_E:  o_sel = 7'b0000100;
            CODE_F:  o_sel = 7'b0000010;
            CODE_G:  o_sel = 7'b0000001;
            default: o_sel = 7'b0000000;
        endcase
    end

endmodule

// File: rtl/circuito_decodificador_funcionalidade_seq.sv
// Sequential function-code decoder: accepted codes become a timed one-hot
// strobe (PULSE_CYCLES long) followed by an all-low guard gap (GAP_CYCLES).
// Optional macro DECOD_QUEUE_EN adds a one-entry holding register so a code
// can be accepted while a strobe is running and starts with no idle cycle.
module circuito_decodificador_funcionalidade_seq
    import circuito_decodificador_funcionalidade_seq_pkg::*;
#(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    circuito_decodificador_funcionalidade_seq_if.slave io_bus,
    output logic [1:0]                               o_dbg_state
);

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [6:0]       r_sel;
    logic             r_null;

    logic             w_ready;
    logic             w_accept;
    logic             w_new_code;
    logic             w_cnt_zero;
    logic             w_done;
    logic             w_start_next;
    logic [2:0]       w_dec_code;
    logic [6:0]       w_dec_sel;

    assign w_accept   = io_bus.CF_VALID & w_ready;
    assign w_new_code = w_accept & (io_bus.CF != CODE_NONE);
    assign w_cnt_zero = (r_cnt == '0);
    // Sequence ends on the last GAP cycle, or the last ACTIVE cycle with no gap
    assign w_done     = w_cnt_zero & ((r_state == ST_GAP) |
                                      ((r_state == ST_ACTIVE) & (GAP_CYCLES == 0)));

`ifdef DECOD_QUEUE_EN
    logic       r_hold_full;
    logic [2:0] r_hold_code;

    assign w_ready      = ~rst & ~r_hold_full;
    // A code arriving on the end cycle bypasses the holding register
    assign w_start_next = w_new_code | r_hold_full;
    assign w_dec_code   = w_accept ? io_bus.CF : r_hold_code;

    // Park a nonzero code that arrives mid-sequence; release it on the end cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_full <= 1'b0;
            r_hold_code <= CODE_NONE;
        end else if (w_done & r_hold_full) begin
            r_hold_full <= 1'b0;
        end else if (w_new_code & (r_state != ST_IDLE) & ~w_done) begin
            r_hold_full <= 1'b1;
            r_hold_code <= io_bus.CF;
        end
    end
`else
    assign w_ready      = ~rst & (r_state == ST_IDLE);
    // Nothing can be accepted while busy, so a sequence always ends in IDLE
    assign w_start_next = 1'b0;
    assign w_dec_code   = io_bus.CF;
`endif

    decodificador_3x7 u_dec (
        .i_code (w_dec_code),
        .o_sel  (w_dec_sel)
    );

    // Main FSM: pulse timing, gap timing and registered one-hot lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_sel   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_new_code) begin
                        r_state <= ST_ACTIVE;
                        r_cnt   <= PULSE_LOAD;
                        r_sel   <= w_dec_sel;
                    end
                end
                ST_ACTIVE: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else if (GAP_CYCLES != 0) begin
                        r_state <= ST_GAP;
                        r_cnt   <= GAP_LOAD;
                        r_sel   <= '0;
                    end else if (w_start_next) begin
                        r_cnt <= PULSE_LOAD;
                        r_sel <= w_dec_sel;
                    end else begin
                        r_state <= ST_IDLE;
                        r_sel   <= '0;
                    end
                end
                ST_GAP: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else if (w_start_next) begin
                        r_state <= ST_ACTIVE;
                        r_cnt   <= PULSE_LOAD;
                        r_sel   <= w_dec_sel;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_sel   <= '0;
                end
            endcase
        end
    end

    // One-cycle NULL_CODE pulse after a 000 code is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_null <= 1'b0;
        end else begin
            r_null <= w_accept & (io_bus.CF == CODE_NONE);
        end
    end

    assign io_bus.CF_READY  = w_ready;
    assign io_bus.SEL       = r_sel;
    assign io_bus.BUSY      = (r_state != ST_IDLE);
    assign io_bus.DONE      = w_done;
    assign io_bus.NULL_CODE = r_null;
    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_circuito_decodificador_funcionalidade_seq.sv
// Bench for the function-code decoder. Two instances: A (pulse 4, gap 1)
// and B (pulse 1, gap 0). The reference keeps a timeline of scheduled
// strobes per instance and derives every output from it each cycle.
module tb_circuito_decodificador_funcionalidade_seq;

    localparam int P_A = 4;
    localparam int G_A = 1;
    localparam int P_B = 1;
    localparam int G_B = 0;
    localparam int MAX_SEQ = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    circuito_decodificador_funcionalidade_seq_if if_a ();
    circuito_decodificador_funcionalidade_seq_if if_b ();

    logic [2:0] cf_v  [2];
    logic       vld_v [2];
    logic [1:0] dbg_a, dbg_b;

    assign if_a.CF       = cf_v[0];
    assign if_a.CF_VALID = vld_v[0];
    assign if_b.CF       = cf_v[1];
    assign if_b.CF_VALID = vld_v[1];

    logic [6:0] sel_o  [2];
    logic       busy_o [2];
    logic       done_o [2];
    logic       null_o [2];
    logic       rdy_o  [2];

    assign sel_o[0]  = if_a.SEL;       assign sel_o[1]  = if_b.SEL;
    assign busy_o[0] = if_a.BUSY;      assign busy_o[1] = if_b.BUSY;
    assign done_o[0] = if_a.DONE;      assign done_o[1] = if_b.DONE;
    assign null_o[0] = if_a.NULL_CODE; assign null_o[1] = if_b.NULL_CODE;
    assign rdy_o[0]  = if_a.CF_READY;  assign rdy_o[1]  = if_b.CF_READY;

    circuito_decodificador_funcionalidade_seq #(
        .PULSE_CYCLES (P_A),
        .GAP_CYCLES   (G_A)
    ) u_dut_a (
        .clk         (clk),
        .rst         (rst),
        .io_bus      (if_a),
        .o_dbg_state (dbg_a)
    );

    circuito_decodificador_funcionalidade_seq #(
        .PULSE_CYCLES (P_B),
        .GAP_CYCLES   (G_B)
    ) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .io_bus      (if_b),
        .o_dbg_state (dbg_b)
    );

    initial begin
        assert (P_A >= 1 && P_A <= 255 && G_A >= 0 && G_A <= 255 &&
                P_B >= 1 && P_B <= 255 && G_B >= 0 && G_B <= 255)
        else begin
            $display("FAIL param_range pulse/gap outside legal range");
            $fatal(1);
        end
    end

    // ---------------- reference timeline ----------------
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [6:0] onehot_tab [8] = '{7'b0000000, 7'b1000000, 7'b0100000, 7'b0010000,
                                   7'b0001000, 7'b0000100, 7'b0000010, 7'b0000001};

    int seq_start [2][MAX_SEQ];
    int seq_code  [2][MAX_SEQ];
    int n_seq     [2] = '{0, 0};
    int last_acc  [2] = '{0, 0};
    bit m_null    [2] = '{1'b0, 1'b0};

    function automatic int plen(int d);
        return (d == 0) ? P_A : P_B;
    endfunction

    function automatic int glen(int d);
        return (d == 0) ? G_A : G_B;
    endfunction

    function automatic bit exp_busy(int d, int k);
        if (rst) return 1'b0;
        for (int i = 0; i < n_seq[d]; i++)
            if (k >= seq_start[d][i] && k <= seq_start[d][i] + plen(d) + glen(d) - 1)
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_done(int d, int k);
        if (rst) return 1'b0;
        for (int i = 0; i < n_seq[d]; i++)
            if (k == seq_start[d][i] + plen(d) + glen(d) - 1)
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [6:0] exp_sel(int d, int k);
        if (rst) return 7'b0;
        for (int i = 0; i < n_seq[d]; i++)
            if (k >= seq_start[d][i] && k <= seq_start[d][i] + plen(d) - 1)
                return onehot_tab[seq_code[d][i]];
        return 7'b0;
    endfunction

    function automatic bit exp_ready(int d, int k);
        if (rst) return 1'b0;
`ifdef DECOD_QUEUE_EN
        // Not ready while an accepted code waits for its start cycle
        if (n_seq[d] > 0 && last_acc[d] <= k && k < seq_start[d][n_seq[d]-1])
            return 1'b0;
        return 1'b1;
`else
        return !exp_busy(d, k);
`endif
    endfunction

    // Record accepts: a strobe for a code accepted at edge N starts in cycle N,
    // or right after the previous sequence when one is still running.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            m_null[d] = 1'b0;
            if (rst) begin
                n_seq[d] = 0;
            end else if (vld_v[d] && exp_ready(d, cyc)) begin
                if (cf_v[d] == 3'd0) begin
                    m_null[d] = 1'b1;
                end else if (n_seq[d] < MAX_SEQ) begin
                    int s;
                    s = cyc + 1;
                    if (n_seq[d] > 0 && seq_start[d][n_seq[d]-1] + plen(d) + glen(d) > s)
                        s = seq_start[d][n_seq[d]-1] + plen(d) + glen(d);
                    seq_start[d][n_seq[d]] = s;
                    seq_code[d][n_seq[d]]  = int'(cf_v[d]);
                    n_seq[d] = n_seq[d] + 1;
                    last_acc[d] = cyc + 1;
                end
            end
        end
        cyc = cyc + 1;
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d cyc=%0d actual=%0h expected=%0h", name, d, cyc, act, exp);
        end
    endtask

    // Compare every output of both instances against the timeline each cycle
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk("sel",    d, 32'(sel_o[d]),  32'(exp_sel(d, cyc)));
            chk("busy",   d, 32'(busy_o[d]), 32'(exp_busy(d, cyc)));
            chk("done",   d, 32'(done_o[d]), 32'(exp_done(d, cyc)));
            chk("null",   d, 32'(null_o[d]), 32'(!rst && m_null[d]));
            chk("ready",  d, 32'(rdy_o[d]),  32'(exp_ready(d, cyc)));
            chk("onehot", d, 32'($countones(sel_o[d]) <= 1), 32'(1));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Present a code and hold it until the cycle where it is accepted
    task automatic send(input int d, input logic [2:0] code, output int acc);
        int guard;
        guard = 0;
        acc = -1;
        cf_v[d]  = code;
        vld_v[d] = 1'b1;
        while (acc < 0 && guard < 200) begin
            @(negedge clk);
            if (exp_ready(d, cyc)) acc = cyc + 1;
            guard++;
        end
        if (acc < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout dut%0d code=%0d actual=not_accepted required=accepted", d, code);
        end
        step();
        vld_v[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (exp_busy(d, cyc) && guard < 600);
        if (guard >= 600) begin
            n_checks++;
            n_errors++;
            $display("FAIL idle_timeout dut%0d actual=busy required=idle", d);
        end
        step();
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int acc;
        int acc2;
        cf_v[0] = 3'd0; cf_v[1] = 3'd0;
        vld_v[0] = 1'b0; vld_v[1] = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", d, 32'(rdy_o[d]),  32'(0));
            chk("rst_sel",   d, 32'(sel_o[d]),  32'(0));
            chk("rst_busy",  d, 32'(busy_o[d]), 32'(0));
            chk("rst_done",  d, 32'(done_o[d]), 32'(0));
            chk("rst_null",  d, 32'(null_o[d]), 32'(0));
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ready", 0, 32'(rdy_o[0]), 32'(1));
        chk("rel_ready", 1, 32'(rdy_o[1]), 32'(1));
        chk("rel_state", 0, 32'(dbg_a), 32'(0));
        step();

        // Code A: four cycles of 1000000, one gap cycle with DONE, then ready
        send(0, 3'b001, acc);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i < 4) chk("t1_sel", 0, 32'(sel_o[0]), 32'(7'b1000000));
            else       chk("t1_sel", 0, 32'(sel_o[0]), 32'(7'b0000000));
            if (i == 4) chk("t1_done", 0, 32'(done_o[0]), 32'(1));
            if (i == 5) chk("t1_ready", 0, 32'(rdy_o[0]), 32'(1));
`ifndef DECOD_QUEUE_EN
            if (i == 0) chk("t1_busy_ready", 0, 32'(rdy_o[0]), 32'(0));
`endif
        end
        step();

        // Sweep every nonzero code
        for (int c = 1; c < 8; c++) begin
            send(0, 3'(c), acc);
            @(negedge clk);
            chk("sweep_sel", 0, 32'(sel_o[0]), 32'(onehot_tab[c]));
            wait_idle(0);
        end

        // Null code, then two back-to-back null codes
        send(0, 3'b000, acc);
        @(negedge clk);
        chk("null_pulse", 0, 32'(null_o[0]), 32'(1));
        chk("null_sel",   0, 32'(sel_o[0]),  32'(0));
        chk("null_busy",  0, 32'(busy_o[0]), 32'(0));
        chk("null_ready", 0, 32'(rdy_o[0]),  32'(1));
        step();
        send(0, 3'b000, acc);
        send(0, 3'b000, acc2);
        chk("null_b2b_gap", 0, 32'(acc2 - acc), 32'(1));
        step();

        // Reset in the second ACTIVE cycle of code G
        send(0, 3'b111, acc);
        step();
        chk("mid_sel", 0, 32'(sel_o[0]), 32'(7'b0000001));
        rst = 1'b1;
        #1;
        chk("async_sel",   0, 32'(sel_o[0]),  32'(0));
        chk("async_busy",  0, 32'(busy_o[0]), 32'(0));
        chk("async_done",  0, 32'(done_o[0]), 32'(0));
        chk("async_state", 0, 32'(dbg_a),     32'(0));
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        send(0, 3'b011, acc);
        @(negedge clk);
        chk("post_rst_sel", 0, 32'(sel_o[0]), 32'(7'b0010000));
        wait_idle(0);

        // Pulse 1, gap 0: code E for one cycle with DONE in the same cycle
        send(1, 3'b101, acc);
        @(negedge clk);
        chk("b_sel",  1, 32'(sel_o[1]),  32'(7'b0000100));
        chk("b_done", 1, 32'(done_o[1]), 32'(1));
        chk("b_busy", 1, 32'(busy_o[1]), 32'(1));
        @(negedge clk);
        chk("b_sel_after",   1, 32'(sel_o[1]),  32'(0));
        chk("b_done_after",  1, 32'(done_o[1]), 32'(0));
        chk("b_ready_after", 1, 32'(rdy_o[1]),  32'(1));
        step();

`ifdef DECOD_QUEUE_EN
        // B then F back-to-back, D stalled until the holding register drains
        send(0, 3'b010, acc);
        send(0, 3'b110, acc2);
        cf_v[0]  = 3'b100;
        vld_v[0] = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i <= 4) chk("q_stall_ready", 0, 32'(rdy_o[0]), 32'(0));
            if (i == 4) begin
                chk("q_done_b", 0, 32'(done_o[0]), 32'(1));
                chk("q_gap_sel", 0, 32'(sel_o[0]), 32'(0));
            end
            if (i == 5) begin
                chk("q_f_sel",   0, 32'(sel_o[0]), 32'(7'b0000010));
                chk("q_f_ready", 0, 32'(rdy_o[0]), 32'(1));
            end
        end
        step();
        vld_v[0] = 1'b0;
        for (int i = 6; i <= 10; i++) begin
            @(negedge clk);
            if (i == 9)  chk("q_done_f", 0, 32'(done_o[0]), 32'(1));
            if (i == 10) chk("q_d_sel",  0, 32'(sel_o[0]),  32'(7'b0001000));
        end
        step();
        wait_idle(0);
`endif

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
